// File: rtl/life_pkg.sv
// Shared grid geometry, paint FSM states and coordinate clamps
// for the cell plotting datapath.
package life_pkg;

    localparam int CELL_PX = 4;
    localparam int GRID_W  = 40;
    localparam int GRID_H  = 30;
    localparam int SCR_W   = GRID_W * CELL_PX;
    localparam int SCR_H   = GRID_H * CELL_PX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLOT = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [5:0] clamp_x(input logic [5:0] v);
        return (v > 6'(GRID_W - 1)) ? 6'(GRID_W - 1) : v;
    endfunction

    function automatic logic [4:0] clamp_y(input logic [5:0] v);
        return (v > 6'(GRID_H - 1)) ? 5'(GRID_H - 1) : v[4:0];
    endfunction

endpackage

// File: rtl/block_scan_counter.sv
// 4-bit pixel offset counter walking the 16 pixels of one cell,
// with synchronous clear, count enable and terminal-count flag.
module block_scan_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] cnt,
    output logic       tc
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == 4'd15);

endmodule

// File: rtl/cell_plot_datapath.sv
// Paints one 4x4 cell of a 40x30 grid onto a 160x120 VGA frame,
// one pixel per cycle, starting on a rising edge of draw.
module cell_plot_datapath
    import life_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       ld_x,
    input  logic       ld_y,
    input  logic       draw,
    input  logic [5:0] data_in,
    input  logic [2:0] colour_in,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    state_t     state_q, state_d;
    logic       draw_low_q, draw_low_d;
    logic [5:0] cell_x_q, cell_x_d;
    logic [4:0] cell_y_q, cell_y_d;
    logic [5:0] snap_x_q, snap_x_d;
    logic [4:0] snap_y_q, snap_y_d;
    logic [2:0] snap_c_q, snap_c_d;

    logic       start;
    logic       cnt_en;
    logic [3:0] offset;
    logic       last_px;

    // Remembers that draw was seen low, so a level held through
    // reset release cannot masquerade as a fresh request.
    assign start = (state_q == IDLE) && draw && draw_low_q;
    assign cnt_en = (state_q == PLOT) && !last_px;

    block_scan_counter u_scan (
        .clock (clock),
        .reset (reset),
        .clr   (start),
        .en    (cnt_en),
        .cnt   (offset),
        .tc    (last_px)
    );

    always_comb begin
        state_d    = state_q;
        draw_low_d = ~draw;
        cell_x_d   = cell_x_q;
        cell_y_d   = cell_y_q;
        snap_x_d   = snap_x_q;
        snap_y_d   = snap_y_q;
        snap_c_d   = snap_c_q;
        unique case (state_q)
            IDLE: begin
                if (ld_x) cell_x_d = clamp_x(data_in);
                if (ld_y) cell_y_d = clamp_y(data_in);
                if (start) begin
                    state_d  = PLOT;
                    snap_x_d = cell_x_q;
                    snap_y_d = cell_y_q;
                    snap_c_d = colour_in;
                end
            end
            PLOT: begin
                if (last_px) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            draw_low_q <= 1'b0;
            cell_x_q   <= '0;
            cell_y_q   <= '0;
            snap_x_q   <= '0;
            snap_y_q   <= '0;
            snap_c_q   <= '0;
        end else begin
            state_q    <= state_d;
            draw_low_q <= draw_low_d;
            cell_x_q   <= cell_x_d;
            cell_y_q   <= cell_y_d;
            snap_x_q   <= snap_x_d;
            snap_y_q   <= snap_y_d;
            snap_c_q   <= snap_c_d;
        end
    end

    // Cell origin is a multiple of 4, so the offset just fills the low bits.
    assign vga_x      = {snap_x_q, offset[1:0]};
    assign vga_y      = {snap_y_q, offset[3:2]};
    assign vga_colour = snap_c_q;
    assign plot       = (state_q == PLOT);
    assign busy       = (state_q == PLOT);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_cell_plot_datapath.sv
// Scoreboard bench: stimulus queues expected pixels and done pulses,
// a negedge monitor compares each plotted pixel and done pulse.
module tb_cell_plot_datapath;

    logic       clock;
    logic       reset;
    logic       ld_x;
    logic       ld_y;
    logic       draw;
    logic [5:0] data_in;
    logic [2:0] colour_in;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   exp_done;
    int   n_checks;
    int   n_fail;

    cell_plot_datapath dut (
        .clock      (clock),
        .reset      (reset),
        .ld_x       (ld_x),
        .ld_y       (ld_y),
        .draw       (draw),
        .data_in    (data_in),
        .colour_in  (colour_in),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_cell(input int cx, input int cy,
                             input logic [2:0] c);
        pix_t p;
        for (int k = 0; k < 16; k++) begin
            p.x = 8'(cx * 4 + (k % 4));
            p.y = 7'(cy * 4 + (k / 4));
            p.c = c;
            exp_q.push_back(p);
        end
        exp_done++;
    endtask

    task automatic load_xy(input logic [5:0] x, input logic [5:0] y);
        ld_x = 1'b1; data_in = x; tick(1);
        ld_x = 1'b0;
        ld_y = 1'b1; data_in = y; tick(1);
        ld_y = 1'b0;
    endtask

    task automatic pulse_draw;
        draw = 1'b1; tick(1);
        draw = 1'b0; tick(20);
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if ({vga_x, vga_y, vga_colour, plot, busy, done} != '0) begin
            n_fail++;
            $display("FAIL %s: x=%0d y=%0d c=%0d plot=%b busy=%b done=%b, need all 0",
                     name, vga_x, vga_y, vga_colour, plot, busy, done);
        end
    endtask

    always @(negedge clock) begin
        pix_t p;
        if (plot) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel: unexpected plot x=%0d y=%0d c=%0d, need none",
                         vga_x, vga_y, vga_colour);
            end else begin
                p = exp_q.pop_front();
                if (vga_x != p.x || vga_y != p.y || vga_colour != p.c) begin
                    n_fail++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d), need (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_colour, p.x, p.y, p.c);
                end
            end
        end
        if (busy != plot) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy: busy=%b, need plot=%b", busy, plot);
        end
        if (done) begin
            n_checks++;
            if (plot || busy) begin
                n_fail++;
                $display("FAIL done_excl: plot=%b busy=%b with done, need 0",
                         plot, busy);
            end else if (exp_done == 0 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL done: pulse with %0d pending pixels, %0d expected, need 0 and >0",
                         exp_q.size(), exp_done);
            end else begin
                exp_done--;
            end
        end
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_done  = 0;
        reset     = 1'b0;
        ld_x      = 1'b0;
        ld_y      = 1'b0;
        draw      = 1'b1;
        data_in   = '0;
        colour_in = '0;
        tick(3);
        check_zero("reset_state");

        // draw held through reset release must not paint
        reset = 1'b1;
        tick(5);
        draw = 1'b0;
        tick(2);

        // basic cell (5,7) in red
        load_xy(6'd5, 6'd7);
        colour_in = 3'b100;
        push_cell(5, 7, 3'b100);
        pulse_draw();

        // out-of-range coordinates clamp to the last cell
        load_xy(6'd63, 6'd63);
        colour_in = 3'b011;
        push_cell(39, 29, 3'b011);
        pulse_draw();

        // both loads in one cycle
        ld_x = 1'b1; ld_y = 1'b1; data_in = 6'd10; tick(1);
        ld_x = 1'b0; ld_y = 1'b0;
        colour_in = 3'b110;
        push_cell(10, 10, 3'b110);
        pulse_draw();

        // draw held high for 40 cycles paints once
        load_xy(6'd0, 6'd29);
        colour_in = 3'b001;
        push_cell(0, 29, 3'b001);
        draw = 1'b1; tick(40);
        draw = 1'b0; tick(4);

        // inputs changing mid-paint do not disturb it
        load_xy(6'd1, 6'd1);
        colour_in = 3'b010;
        push_cell(1, 1, 3'b010);
        draw = 1'b1; tick(1);
        draw = 1'b0; tick(8);
        ld_x = 1'b1; data_in = 6'd2; colour_in = 3'b111; tick(1);
        ld_x = 1'b0; tick(12);
        // ld_x during the paint was ignored, cell_x still 1
        push_cell(1, 1, 3'b111);
        pulse_draw();

        // reset at pixel 6 aborts the paint
        load_xy(6'd2, 6'd3);
        colour_in = 3'b101;
        push_cell(2, 3, 3'b101);
        exp_q = exp_q[0:6];
        exp_done--;
        draw = 1'b1; tick(1);
        draw = 1'b0; tick(6);
        reset = 1'b0; tick(1);
        check_zero("abort_reset");
        tick(1);
        check_zero("abort_hold");
        reset = 1'b1; tick(2);
        check_zero("post_reset_idle");

        // next edge paints normally from cleared cell registers
        colour_in = 3'b011;
        push_cell(0, 0, 3'b011);
        pulse_draw();

        tick(3);
        n_checks++;
        if (exp_q.size() != 0 || exp_done != 0) begin
            n_fail++;
            $display("FAIL drain: %0d pixels and %0d done pulses left, need 0 and 0",
                     exp_q.size(), exp_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
